// File: rtl/conv_enc_k4_if.sv
// Handshake bundle between a serial bit source, the convolutional encoder
// and the symbol sink. The encoder takes the slave view.
interface conv_enc_if;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       out_valid;
   logic [1:0] out_pair;
   logic       out_last;
   logic       out_ready;

   modport slave (
      input  in_valid,
      input  in_bit,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_pair,
      output out_last
   );

   modport master (
      output in_valid,
      output in_bit,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_pair,
      input  out_last
   );
endinterface

// File: rtl/conv_enc_k4.sv
// Rate-1/2 convolutional encoder with zero-tail termination.
// One 2-bit symbol {G0 parity, G1 parity} per input bit. After FRAME_LEN data
// bits, K-1 zero bits are pushed internally so the trellis ends in state 0.
// A single output register gives latency 1 and full throughput under a
// valid/ready handshake.
module conv_enc_k4 #(
   parameter int           K         = 4,
   parameter logic [K-1:0] G0        = 4'b1101,
   parameter logic [K-1:0] G1        = 4'b1011,
   parameter int           FRAME_LEN = 64
) (
   input  logic     clk,
   input  logic     rst,
   conv_enc_if.slave bus,
   output logic     busy
);

   localparam int            CW        = $clog2(FRAME_LEN + 1);
   localparam int            TW        = (K > 2) ? $clog2(K) : 1;
   localparam logic [CW-1:0] LAST_DATA = CW'(FRAME_LEN - 1);
   localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_t;

   state_t        state;
   logic [K-2:0]  sr;
   logic [CW-1:0] bit_cnt;
   logic [TW-1:0] tail_cnt;

   logic          slot_free;
   logic          accept;
   logic          tail_step;
   logic          encode;
   logic          enc_bit;
   logic          last_tail;
   logic [K-1:0]  win;

   // Even parity over the taps selected by a generator.
   function automatic logic tap_parity(input logic [K-1:0] w, input logic [K-1:0] g);
      return ^(w & g);
   endfunction

   // Handshake decode: the output register may be refilled when it is empty
   // or being drained this cycle; tail bits are generated internally.
   always_comb begin
      slot_free = !bus.out_valid || bus.out_ready;
      accept    = bus.in_valid && bus.in_ready;
      tail_step = (state == TAIL) && slot_free;
      encode    = accept || tail_step;
      enc_bit   = (state == TAIL) ? 1'b0 : bus.in_bit;
      win       = {enc_bit, sr};
      last_tail = (state == TAIL) && (tail_cnt == LAST_TAIL);
   end

   assign bus.in_ready = slot_free && ((state == IDLE) || (state == DATA)) && !rst;
   assign busy         = (state != IDLE);

   // Frame sequencing, shift register and the registered output symbol.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sr            <= '0;
         bit_cnt       <= '0;
         tail_cnt      <= '0;
         bus.out_valid <= 1'b0;
         bus.out_pair  <= 2'b00;
         bus.out_last  <= 1'b0;
      end else begin
         if (encode) begin
            bus.out_pair  <= {tap_parity(win, G0), tap_parity(win, G1)};
            bus.out_last  <= last_tail;
            bus.out_valid <= 1'b1;
            sr            <= win[K-1:1];
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
         end else begin
            bus.out_valid <= bus.out_valid;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  bit_cnt <= CW'(1);
                  state   <= (FRAME_LEN == 1) ? TAIL : DATA;
               end else begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (accept) begin
                  bit_cnt <= bit_cnt + CW'(1);
                  if (bit_cnt == LAST_DATA) begin
                     state <= TAIL;
                  end else begin
                     state <= DATA;
                  end
               end else begin
                  state <= DATA;
               end
            end
            TAIL: begin
               if (tail_step) begin
                  if (last_tail) begin
                     tail_cnt <= '0;
                     bit_cnt  <= '0;
                     state    <= IDLE;
                  end else begin
                     tail_cnt <= tail_cnt + TW'(1);
                  end
               end else begin
                  state <= TAIL;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_enc_k4.sv
// Bench for conv_enc_k4: a short-frame instance (FRAME_LEN=3) and a
// default-frame instance (FRAME_LEN=64). Expected symbols are queued when
// stimulus is issued; a monitor pops and compares on every accepted symbol.
module tb_conv_enc_k4;

   logic clk = 1'b0;
   logic rst;
   logic a_busy;
   logic b_busy;

   always #5 clk = ~clk;

   conv_enc_if a_if ();
   conv_enc_if b_if ();

   conv_enc_k4 #(.FRAME_LEN(3)) dut_a (
      .clk  (clk),
      .rst  (rst),
      .bus  (a_if),
      .busy (a_busy)
   );

   conv_enc_k4 #(.FRAME_LEN(64)) dut_b (
      .clk  (clk),
      .rst  (rst),
      .bus  (b_if),
      .busy (b_busy)
   );

   typedef struct packed {
      logic [1:0] pair;
      logic       last;
   } sym_t;

   sym_t q_a[$];
   sym_t q_b[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int a_pos = 0;
   int a_first = 0;
   int a_last_cyc = 0;
   int b_seen = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   task automatic push_a(input logic [1:0] p, input logic l);
      sym_t s;
      s.pair = p;
      s.last = l;
      q_a.push_back(s);
   endtask

   // Reference encoder: p1 = b^d1^d3, p0 = b^d2^d3 (d1 = previous bit).
   task automatic model_push(input bit to_b, input int n, input logic bits[]);
      logic d1, d2, d3, bi;
      sym_t s;
      d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
      for (int i = 0; i < n + 3; i++) begin
         bi     = (i < n) ? bits[i] : 1'b0;
         s.pair = {bi ^ d1 ^ d3, bi ^ d2 ^ d3};
         s.last = (i == n + 2);
         if (to_b) q_b.push_back(s);
         else      q_a.push_back(s);
         d3 = d2; d2 = d1; d1 = bi;
      end
   endtask

   task automatic send_a(input logic b);
      int  t;
      bit  done;
      t    = 0;
      done = 1'b0;
      a_if.in_valid = 1'b1;
      a_if.in_bit   = b;
      while (!done && t < 50) begin
         @(negedge clk);
         if (a_if.in_ready) done = 1'b1;
         @(posedge clk);
         #1;
         t++;
      end
      a_if.in_valid = 1'b0;
      if (!done) fail_now("a_send_timeout");
   endtask

   task automatic drain_a();
      int t;
      t = 0;
      while (q_a.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("a_drain", q_a.size(), 0);
   endtask

   task automatic drain_b();
      int t;
      t = 0;
      while (q_b.size() != 0 && t < 400) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("b_drain", q_b.size(), 0);
   endtask

   // Monitor: compare every handshaken symbol against the scoreboard queues.
   initial begin
      sym_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (a_if.out_valid && a_if.out_ready) begin
            if (q_a.size() == 0) begin
               fail_now("a_unexpected_symbol");
            end else begin
               e = q_a.pop_front();
               chk("a_pair", int'(a_if.out_pair), int'(e.pair));
               chk("a_last", int'(a_if.out_last), int'(e.last));
               if (a_pos == 0) a_first = cyc;
               if (a_if.out_last) begin
                  chk("a_frame_symbols", a_pos + 1, 6);
                  a_last_cyc = cyc;
                  a_pos = 0;
               end else begin
                  a_pos++;
               end
            end
         end
         if (rst) a_pos = 0;
         if (b_seen > 0 && b_seen < 134) chk("b_no_gap", int'(b_if.out_valid), 1);
         if (b_if.out_valid && b_if.out_ready) begin
            if (q_b.size() == 0) begin
               fail_now("b_unexpected_symbol");
            end else begin
               e = q_b.pop_front();
               chk("b_pair", int'(b_if.out_pair), int'(e.pair));
               chk("b_last", int'(b_if.out_last), int'(e.last));
               b_seen++;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic bits_r[];
      logic bits_b[];
      int   idx, zeros, t;
      bit   acc;

      rst = 1'b1;
      a_if.in_valid = 1'b0; a_if.in_bit = 1'b0; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.in_bit = 1'b0; b_if.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(a_if.out_valid), 0);
      chk("rst_out_pair", int'(a_if.out_pair), 0);
      chk("rst_out_last", int'(a_if.out_last), 0);
      chk("rst_busy", int'(a_busy), 0);
      chk("rst_in_ready", int'(a_if.in_ready), 0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", int'(a_if.in_ready), 1);
      @(posedge clk); #1;

      // Scenario 1: bits 1,0,1 -> 11,10,10,01,01,11
      push_a(2'b11, 1'b0); push_a(2'b10, 1'b0); push_a(2'b10, 1'b0);
      push_a(2'b01, 1'b0); push_a(2'b01, 1'b0); push_a(2'b11, 1'b1);
      send_a(1'b1); send_a(1'b0); send_a(1'b1);
      drain_a();
      chk("s1_consecutive_span", a_last_cyc - a_first, 5);

      // Scenario 2: all-zero frame
      for (int i = 0; i < 6; i++) push_a(2'b00, (i == 5));
      send_a(1'b0); send_a(1'b0); send_a(1'b0);
      drain_a();
      @(posedge clk); #1;
      chk("s2_busy_after", int'(a_busy), 0);

      // Scenario 3: backpressure for 3 cycles while symbol 10 is presented
      push_a(2'b11, 1'b0); push_a(2'b10, 1'b0); push_a(2'b10, 1'b0);
      push_a(2'b01, 1'b0); push_a(2'b01, 1'b0); push_a(2'b11, 1'b1);
      send_a(1'b1); send_a(1'b0);
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      a_if.in_bit    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("s3_hold_pair", int'(a_if.out_pair), 2);
         chk("s3_hold_valid", int'(a_if.out_valid), 1);
         chk("s3_in_ready_low", int'(a_if.in_ready), 0);
         @(posedge clk); #1;
      end
      a_if.out_ready = 1'b1;
      send_a(1'b1);
      drain_a();

      // Scenario 5: reset after the 2nd data bit, then a clean frame
      push_a(2'b11, 1'b0); push_a(2'b10, 1'b0);
      send_a(1'b1); send_a(1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("s5_in_ready_in_rst", int'(a_if.in_ready), 0);
      @(posedge clk); #1;
      chk("s5_out_valid_after_rst", int'(a_if.out_valid), 0);
      chk("s5_busy_after_rst", int'(a_busy), 0);
      rst = 1'b0;
      push_a(2'b11, 1'b0); push_a(2'b10, 1'b0); push_a(2'b10, 1'b0);
      push_a(2'b01, 1'b0); push_a(2'b01, 1'b0); push_a(2'b11, 1'b1);
      send_a(1'b1); send_a(1'b0); send_a(1'b1);
      drain_a();

      // Scenario 6: in_valid every other cycle, random data, two frames
      for (int f = 0; f < 2; f++) begin
         bits_r = new[3];
         for (int i = 0; i < 3; i++) bits_r[i] = 1'($urandom_range(1, 0));
         model_push(1'b0, 3, bits_r);
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            send_a(bits_r[i]);
         end
         drain_a();
      end

      // Scenario 4: FRAME_LEN=64, continuous valid/ready, two frames back to back
      bits_b = new[128];
      for (int i = 0; i < 128; i++) bits_b[i] = 1'($urandom_range(1, 0));
      bits_r = new[64];
      for (int i = 0; i < 64; i++) bits_r[i] = bits_b[i];
      model_push(1'b1, 64, bits_r);
      for (int i = 0; i < 64; i++) bits_r[i] = bits_b[64 + i];
      model_push(1'b1, 64, bits_r);
      idx = 0; zeros = 0; t = 0;
      b_if.in_valid = 1'b1;
      b_if.in_bit   = bits_b[0];
      while (idx < 128 && t < 400) begin
         @(negedge clk);
         acc = b_if.in_ready;
         if (!acc) zeros++;
         @(posedge clk); #1;
         if (acc) idx++;
         if (idx < 128) b_if.in_bit = bits_b[idx];
         t++;
      end
      b_if.in_valid = 1'b0;
      chk("s4_bits_accepted", idx, 128);
      chk("s4_tail_ready_low_cycles", zeros, 3);
      drain_b();
      chk("s4_symbols_total", b_seen, 134);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
